// File: rtl/fetch_seq.sv
// ---------------------------------------------------------------------------
// fetch_seq
//
// Instruction-fetch sequencer between the word-addressed PC register and
// instruction memory. Runs the req/ready handshake and holds the fetched
// word for decode. It also produces the PC register's next value (hold,
// increment, redirect, boot), because the PC register has no enable of its
// own.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   pc_q         current PC register output
//   pc_d         next PC value, wired to the PC register input
//   imem_addr    fetch address (combinationally equal to pc_q)
//   imem_req     fetch request to instruction memory
//   imem_ready   memory returns imem_data this cycle
//   imem_data    fetched word
//   instr        registered instruction for decode
//   instr_valid  instr is valid this cycle
//   stall        downstream cannot accept; hold instr
//   redir_valid  branch / jump / flush request
//   redir_target redirect word address
// ---------------------------------------------------------------------------
module fetch_seq #(
  parameter int AW = 30,
  parameter int IW = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_q,
  output logic [AW-1:0] pc_d,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  input  logic          imem_ready,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          stall,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_target
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    ISSUE = 2'd2
  } state_t;

  localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state;
  logic          pend_valid;
  logic [AW-1:0] pend_target;

  // Memory sees the PC register directly; stability during a handshake comes
  // from pc_d holding pc_q until the ready cycle.
  assign imem_addr = pc_q;

  // Next-PC selection. A live redirect always beats an older pending one,
  // so the newest control-flow request wins.
  always_comb begin
    pc_d = pc_q;
    if (!rst) begin
      pc_d = RESET_PC;
    end else begin
      case (state)
        BOOT: pc_d = RESET_PC;
        REQ: begin
          // Only after the handshake completes may the address move; the
          // wrong-path word returned in that cycle is dropped.
          if (imem_ready && (redir_valid || pend_valid))
            pc_d = redir_valid ? redir_target : pend_target;
        end
        ISSUE: begin
          if (!stall) begin
            if (redir_valid)     pc_d = redir_target;
            else if (pend_valid) pc_d = pend_target;
            else                 pc_d = pc_q + PC_ONE;
          end
        end
        default: pc_d = RESET_PC;
      endcase
    end
  end

  // Control FSM with registered imem_req / instr_valid. Redirects that cannot
  // be applied immediately (mid-handshake or while stalled) are parked in a
  // single pending slot, newest overwriting oldest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ready) begin
            if (redir_valid || pend_valid) begin
              pend_valid <= 1'b0;
            end else begin
              instr       <= imem_data;
              instr_valid <= 1'b1;
              imem_req    <= 1'b0;
              state       <= ISSUE;
            end
          end else if (redir_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pend_valid  <= 1'b0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end else if (redir_valid) begin
            pend_valid  <= 1'b1;
            pend_target <= redir_target;
          end
        end
        default: begin
          state       <= BOOT;
          instr_valid <= 1'b0;
          imem_req    <= 1'b0;
          pend_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// ---------------------------------------------------------------------------
// tb_fetch_seq
//
// Bench for fetch_seq. Models the PC register (plain flop, no enable) and a
// memory whose data word equals its address. Per-cycle expectations come
// from a vector table; expected instruction words are queued when the
// accepting stimulus is driven and popped when instr_valid rises.
// ---------------------------------------------------------------------------
module tb_fetch_seq;

  localparam int AW = 30;
  localparam int IW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] imem_addr;
  logic          imem_req;
  logic          imem_ready;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          stall;
  logic          redir_valid;
  logic [AW-1:0] redir_target;

  fetch_seq #(.AW(AW), .IW(IW), .RESET_PC('0)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_q         (pc_q),
    .pc_d         (pc_d),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: no enable, no reset of its own
  initial pc_q = '0;
  always @(posedge clk) pc_q <= pc_d;

  // Memory returns its own address as data
  assign imem_data = {2'b00, imem_addr};

  typedef struct {
    logic          ready;
    logic          stl;
    logic          rv;
    logic [AW-1:0] rt;
    logic          accept;
    logic          exp_req;
    logic          exp_valid;
    logic [AW-1:0] exp_pc_d;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t          vecs[$];
  logic [IW-1:0] sb_q[$];
  logic [IW-1:0] last_word;
  logic          prev_valid;
  int            pass_cnt;
  int            total_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add_row(input logic ready, input logic stl, input logic rv,
                         input logic [AW-1:0] rt, input logic accept,
                         input logic req, input logic valid,
                         input logic [AW-1:0] pcd, input logic [AW-1:0] addr);
    vec_t v;
    v.ready = ready; v.stl = stl; v.rv = rv; v.rt = rt; v.accept = accept;
    v.exp_req = req; v.exp_valid = valid; v.exp_pc_d = pcd; v.exp_addr = addr;
    vecs.push_back(v);
  endtask

  // Scoreboard side: pop on each rising instr_valid, check hold while valid stays high
  task automatic sb_sample(input string tag);
    if (instr_valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("[TB] FAIL %s instr: got %h expected none (scoreboard empty)", tag, instr);
      end else begin
        last_word = sb_q.pop_front();
        check({tag, " instr"}, instr, last_word);
      end
    end else if (instr_valid && prev_valid) begin
      check({tag, " instr held"}, instr, last_word);
    end
    prev_valid = instr_valid;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    imem_ready   = v.ready;
    stall        = v.stl;
    redir_valid  = v.rv;
    redir_target = v.rt;
    if (v.accept) sb_q.push_back({2'b00, v.exp_addr});
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    check({tag, " imem_req"},    {31'd0, imem_req},    {31'd0, v.exp_req});
    check({tag, " instr_valid"}, {31'd0, instr_valid}, {31'd0, v.exp_valid});
    check({tag, " pc_d"},        {2'b00, pc_d},        {2'b00, v.exp_pc_d});
    check({tag, " imem_addr"},   {2'b00, imem_addr},   {2'b00, v.exp_addr});
    sb_sample(tag);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " imem_req"},    {31'd0, imem_req},    32'd0);
    check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, " instr"},       instr,                32'd0);
    check({tag, " pc_d"},        {2'b00, pc_d},        32'd0);
  endtask

  initial begin
    vec_t v;
    pass_cnt     = 0;
    total_cnt    = 0;
    prev_valid   = 1'b0;
    last_word    = '0;
    rst          = 1'b0;
    imem_ready   = 1'b0;
    stall        = 1'b0;
    redir_valid  = 1'b0;
    redir_target = '0;

    //       rdy stl rv  rt            acc req vld pc_d          addr
    add_row(1, 0, 0, 30'h0,        0, 0, 0, 30'h0,        30'h0);        // BOOT
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h0,        30'h0);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h1,        30'h0);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h1,        30'h1);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h2,        30'h1);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h2,        30'h2);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h3,        30'h2);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h3,        30'h3);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h4,        30'h3);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h4,        30'h4);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h5,        30'h4);
    add_row(0, 0, 0, 30'h0,        0, 1, 0, 30'h5,        30'h5);        // wait 1
    add_row(0, 0, 0, 30'h0,        0, 1, 0, 30'h5,        30'h5);        // wait 2
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h5,        30'h5);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h6,        30'h5);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h6,        30'h6);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h7,        30'h6);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h7,        30'h7);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h8,        30'h7);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h8,        30'h8);
    add_row(1, 1, 0, 30'h0,        0, 0, 1, 30'h8,        30'h8);        // stall 1
    add_row(1, 1, 1, 30'h100,      0, 0, 1, 30'h8,        30'h8);        // stall 2 + redirect
    add_row(1, 1, 0, 30'h0,        0, 0, 1, 30'h8,        30'h8);
    add_row(1, 1, 0, 30'h0,        0, 0, 1, 30'h8,        30'h8);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h100,      30'h8);        // release
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h100,      30'h100);
    add_row(1, 0, 1, 30'h3,        0, 0, 1, 30'h3,        30'h100);      // redirect in ISSUE
    add_row(0, 0, 1, 30'h20,       0, 1, 0, 30'h3,        30'h3);        // redirect in REQ
    add_row(0, 0, 1, 30'h40,       0, 1, 0, 30'h3,        30'h3);        // newer overwrites
    add_row(1, 0, 0, 30'h0,        0, 1, 0, 30'h40,       30'h3);        // word 3 discarded
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h40,       30'h40);
    add_row(1, 0, 1, 30'h3FFFFFFF, 0, 0, 1, 30'h3FFFFFFF, 30'h40);
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h3FFFFFFF, 30'h3FFFFFFF);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h0,        30'h3FFFFFFF); // wrap
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h0,        30'h0);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h1,        30'h0);
    add_row(1, 0, 1, 30'h55,       0, 1, 0, 30'h55,       30'h1);        // ready + redirect together
    add_row(1, 0, 0, 30'h0,        1, 1, 0, 30'h55,       30'h55);
    add_row(1, 0, 0, 30'h0,        0, 0, 1, 30'h56,       30'h55);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_state("reset");
    check("reset imem_addr", {2'b00, imem_addr}, {2'b00, pc_q});
    rst = 1'b1;
    #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      if (i != 0) applyStimulus(v);
      else begin
        imem_ready = v.ready; stall = v.stl; redir_valid = v.rv; redir_target = v.rt;
        #1;
      end
      checkOutput(v, i);
    end

    // Reset asserted mid-REQ at pc 0x56 with memory ready
    @(negedge clk);
    imem_ready  = 1'b1;
    stall       = 1'b0;
    redir_valid = 1'b0;
    #1;
    check("midreq imem_req",  {31'd0, imem_req},  32'd1);
    check("midreq imem_addr", {2'b00, imem_addr}, 32'h56);
    #2;
    rst = 1'b0;
    #1;
    check_reset_state("async_rst");
    prev_valid = instr_valid;
    repeat (2) begin
      @(negedge clk);
      #1;
      check_reset_state("held_rst");
    end
    rst = 1'b1;
    #1;
    check("boot imem_req",    {31'd0, imem_req},    32'd0);
    check("boot instr_valid", {31'd0, instr_valid}, 32'd0);
    check("boot pc_d",        {2'b00, pc_d},        32'd0);
    check("boot imem_addr",   {2'b00, imem_addr},   32'd0);
    sb_sample("boot");
    v = '{ready:1'b1, stl:1'b0, rv:1'b0, rt:30'h0, accept:1'b1,
          exp_req:1'b1, exp_valid:1'b0, exp_pc_d:30'h0, exp_addr:30'h0};
    applyStimulus(v);
    checkOutput(v, 100);
    v = '{ready:1'b1, stl:1'b0, rv:1'b0, rt:30'h0, accept:1'b0,
          exp_req:1'b0, exp_valid:1'b1, exp_pc_d:30'h1, exp_addr:30'h0};
    applyStimulus(v);
    checkOutput(v, 101);

    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer between the 30-bit word-addressed PC register and instruction memory. It consumes the PC register output, runs the request/ready handshake with instruction memory, and holds the fetched word for the decode stage. It generates the PC register's next-value input, covering hold, increment, redirect and boot cases. The PC register has no enable, so this block drives its current value back whenever the PC must hold.

## Interface
- AW, 30, PC / address width in words
- IW, 32, instruction width
- RESET_PC, 0, first fetch address after reset

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-low
- pc_q  in  AW  current PC register output
- pc_d  out  AW  next PC value, wired to the PC register input
- imem_addr  out  AW  fetch address, combinationally equal to pc_q
- imem_req  out  1  fetch request
- imem_ready  in  1  memory returns imem_data this cycle
- imem_data  in  IW  fetched word
- instr  out  IW  registered instruction for decode
- instr_valid  out  1  instr is valid for the current cycle
- stall  in  1  decode/execute cannot accept; hold instr
- redir_valid  in  1  branch, jump or flush request
- redir_target  in  AW  redirect word address

## Operation
- States:
  - BOOT: entered on reset.
  - REQ: fetch outstanding.
  - ISSUE: instr presented.
- BOOT:
  - pc_d = RESET_PC; imem_req = 0; instr_valid = 0.
  - Next state is REQ unconditionally, so the PC register loads RESET_PC.
- REQ:
  - imem_req = 1; pc_d = pc_q (hold).
  - On imem_ready with no redirect pending and redir_valid = 0: instr <= imem_data, go to ISSUE.
  - On imem_ready with a redirect pending or redir_valid = 1: discard imem_data, pc_d = redirect target, stay in REQ, clear pending.
  - On redir_valid without imem_ready: latch the target into the pending register. A newer redirect overwrites an older one. The request continues at the old address, because memory must not see the address change mid-handshake.
- ISSUE:
  - instr_valid = 1; imem_req = 0.
  - stall = 0:
    - Next PC, highest priority first: redir_valid → redir_target; pending → pending target; otherwise pc_q + 1.
    - Clear pending and go to REQ.
  - stall = 1:
    - pc_d = pc_q; instr and instr_valid held.
    - A redir_valid arriving now is latched into pending and applied when the stall releases.
- Arithmetic: pc_q + 1 is modulo 2^AW, so all-ones wraps to 0.
- imem_ready while imem_req = 0 is ignored.
- Reset, including mid-operation:
  - Takes effect asynchronously: state = BOOT; instr = 0; instr_valid = 0; imem_req = 0; pending cleared.
  - An in-flight memory response is dropped.
  - pc_d = RESET_PC while rst is low.

## Timing
- Reset values: imem_req 0, instr_valid 0, instr 0, pc_d RESET_PC; imem_addr follows pc_q.
- First request: the cycle after rst deasserts is BOOT; REQ starts one cycle later with pc_q = RESET_PC.
- Zero-wait memory gives one instruction every 2 cycles (REQ, ISSUE). Each memory wait state adds 1 cycle.
- instr updates on the edge that ends the ready cycle. instr_valid is high for every ISSUE cycle.
- Redirect penalty:
  - Applied in ISSUE: the next REQ uses the target with no dead cycle.
  - Applied in REQ: one extra REQ round trip, since the wrong-path word is discarded.
- imem_addr and imem_req stay stable from request until the ready cycle, inclusive.

## Test plan
- Reset, then imem_ready tied to 1 with data = address: instr sequence 0, 1, 2, 3 on ISSUE cycles every 2 clocks; imem_req alternates 1/0.
- 2 wait states at pc 5: REQ lasts 3 cycles with imem_addr = 5 throughout; instr = word 5; the next fetch is at 6.
- stall held 4 cycles in ISSUE at pc 8 with redir_valid pulsed to 0x100 in cycle 2: instr is unchanged and pc_d = 8 during the stall; after release the next fetch is at 0x100, not 9.
- redir_valid to 0x40 during REQ at pc 3, ready 2 cycles later: no instr_valid for word 3; pc becomes 0x40; instr 0x40 is presented next.
- pc_q = 0x3FFFFFFF, no stall, no redirect: the next fetch address is 0.
- rst driven low mid-REQ while imem_ready = 1: instr_valid stays 0, instr = 0; after release the fetch restarts at RESET_PC after one BOOT cycle.
